// File: rtl/axi4lite_pkg.sv
// ============================================================================
// Module : axi4lite_pkg
// Brief  : Shared types and constants for the AXI4-Lite to Avalon-MM bridge.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package axi4lite_pkg;

  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam int         AMM_DW    = 32;
  localparam int         AMM_AW    = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    AMM_WR = 3'd1,
    AMM_RD = 3'd2,
    B_RESP = 3'd3,
    R_RESP = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/amm_if.sv
// ============================================================================
// Module : amm_if
// Brief  : Avalon-MM command/response bundle with master and slave views.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface amm_if;
  import axi4lite_pkg::*;

  logic [AMM_AW-1:0]   address;
  logic [AMM_DW-1:0]   writedata;
  logic [AMM_DW/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [AMM_DW-1:0]   readdata;
  logic                waitrequest;

  modport master (
    output address, writedata, byteenable, read, write,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, writedata, byteenable, read, write,
    output readdata, waitrequest
  );

endinterface

`default_nettype wire

// File: rtl/axi4lite_amm_bridge.sv
// ============================================================================
// Module : axi4lite_amm_bridge
// Brief  : AXI4-Lite slave to Avalon-MM master, one transaction at a time.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module axi4lite_amm_bridge
  import axi4lite_pkg::*;
#(
  parameter logic [31:0] P_ADDR_MASK = 32'hFFFF_FFFF,
  parameter bit          P_RD_FIRST  = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_awaddr,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_wvalid,
  output logic        s_wready,
  output logic [1:0]  s_bresp,
  output logic        s_bvalid,
  input  logic        s_bready,
  input  logic [31:0] s_araddr,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rvalid,
  input  logic        s_rready,
  amm_if.master       o
);

  state_t      state_q, state_d;
  logic        prio_rd_q, prio_rd_d;
  logic [31:0] address_q, address_d;
  logic [31:0] writedata_q, writedata_d;
  logic [3:0]  byteenable_q, byteenable_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic        bvalid_q, bvalid_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;

  logic wr_req, rd_req, grant_wr, grant_rd, idle_ok;

  // A write needs AW and W together; a lone half is never accepted.
  assign wr_req   = s_awvalid & s_wvalid;
  assign rd_req   = s_arvalid;
  assign grant_wr = wr_req & (~rd_req | ~prio_rd_q);
  assign grant_rd = rd_req & ~grant_wr;
  assign idle_ok  = (state_q == IDLE) & ~reset;

  assign s_awready = idle_ok & grant_wr;
  assign s_wready  = idle_ok & grant_wr;
  assign s_arready = idle_ok & grant_rd;

  assign s_bresp  = RESP_OKAY;
  assign s_rresp  = RESP_OKAY;
  assign s_bvalid = bvalid_q;
  assign s_rvalid = rvalid_q;
  assign s_rdata  = rdata_q;

  assign o.address    = address_q;
  assign o.writedata  = writedata_q;
  assign o.byteenable = byteenable_q;
  assign o.read       = read_q;
  assign o.write      = write_q;

  always_comb begin
    state_d      = state_q;
    prio_rd_d    = prio_rd_q;
    address_d    = address_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    read_d       = read_q;
    write_d      = write_q;
    bvalid_d     = bvalid_q;
    rvalid_d     = rvalid_q;
    rdata_d      = rdata_q;

    case (state_q)
      IDLE: begin
        if (grant_wr) begin
          address_d    = s_awaddr & P_ADDR_MASK;
          writedata_d  = s_wdata;
          byteenable_d = s_wstrb;
          write_d      = 1'b1;
          prio_rd_d    = 1'b1;
          state_d      = AMM_WR;
        end else if (grant_rd) begin
          address_d    = s_araddr & P_ADDR_MASK;
          byteenable_d = 4'hF;
          read_d       = 1'b1;
          prio_rd_d    = 1'b0;
          state_d      = AMM_RD;
        end
      end
      AMM_WR: begin
        if (!o.waitrequest) begin
          write_d  = 1'b0;
          bvalid_d = 1'b1;
          state_d  = B_RESP;
        end
      end
      AMM_RD: begin
        if (!o.waitrequest) begin
          rdata_d  = o.readdata;
          read_d   = 1'b0;
          rvalid_d = 1'b1;
          state_d  = R_RESP;
        end
      end
      B_RESP: begin
        if (s_bready) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      R_RESP: begin
        if (s_rready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Async reset drops any in-flight Avalon command without waiting for clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      prio_rd_q    <= P_RD_FIRST;
      address_q    <= '0;
      writedata_q  <= '0;
      byteenable_q <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      bvalid_q     <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      prio_rd_q    <= prio_rd_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      read_q       <= read_d;
      write_q      <= write_d;
      bvalid_q     <= bvalid_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi4lite_amm_bridge.sv
// ============================================================================
// Module : tb_axi4lite_amm_bridge
// Brief  : Directed self-checking bench for the AXI4-Lite to Avalon-MM bridge.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_axi4lite_amm_bridge;
  import axi4lite_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_awvalid = 1'b0, s_wvalid = 1'b0, s_arvalid = 1'b0;
  logic        s_bready = 1'b0, s_rready = 1'b0;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = '0;

  logic        s_awready, s_wready, s_arready, s_bvalid, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;
  logic        m_awready, m_wready, m_arready, m_bvalid, m_rvalid;
  logic [1:0]  m_bresp, m_rresp;
  logic [31:0] m_rdata;

  amm_if amm ();
  amm_if amm_m ();
  assign amm.waitrequest   = waitrequest;
  assign amm.readdata      = readdata;
  assign amm_m.waitrequest = waitrequest;
  assign amm_m.readdata    = readdata;

  axi4lite_amm_bridge dut (
    .clk(clk), .reset(reset),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .o(amm.master)
  );

  // Same stimulus, narrow address mask: only its o.address is inspected.
  axi4lite_amm_bridge #(.P_ADDR_MASK(32'h0000_0FFC)) dut_m (
    .clk(clk), .reset(reset),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(m_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(m_wready),
    .s_bresp(m_bresp), .s_bvalid(m_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(m_arready),
    .s_rdata(m_rdata), .s_rresp(m_rresp), .s_rvalid(m_rvalid), .s_rready(s_rready),
    .o(amm_m.master)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  logic [3:0] grants;
  int         ng;
  logic       both_hi;

  initial begin
    // Reset state, with every request asserted to prove readies are gated.
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    @(negedge clk);
    chk("rst_awready", 32'(s_awready), 32'd0);
    chk("rst_wready", 32'(s_wready), 32'd0);
    chk("rst_arready", 32'(s_arready), 32'd0);
    chk("rst_write", 32'(amm.write), 32'd0);
    chk("rst_read", 32'(amm.read), 32'd0);
    chk("rst_bvalid", 32'(s_bvalid), 32'd0);
    chk("rst_rvalid", 32'(s_rvalid), 32'd0);
    chk("rst_address", amm.address, 32'd0);
    chk("rst_rdata", s_rdata, 32'd0);
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Write with 3 waitrequest cycles.
    @(negedge clk);
    s_awaddr = 32'h0000_0010; s_wdata = 32'hDEAD_BEEF; s_wstrb = 4'b0011;
    s_awvalid = 1'b1; s_wvalid = 1'b1; waitrequest = 1'b1;
    #1;
    chk("wr_awready", 32'(s_awready), 32'd1);
    chk("wr_wready", 32'(s_wready), 32'd1);
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk("wr_write_hi", 32'(amm.write), 32'd1);
      chk("wr_address", amm.address, 32'h0000_0010);
      chk("wr_wdata", amm.writedata, 32'hDEAD_BEEF);
      chk("wr_be", 32'(amm.byteenable), 32'h3);
      if (i == 3) waitrequest = 1'b0;
    end
    @(negedge clk);
    chk("wr_write_lo", 32'(amm.write), 32'd0);
    chk("wr_bvalid", 32'(s_bvalid), 32'd1);
    chk("wr_bresp", 32'(s_bresp), 32'd0);
    s_bready = 1'b1;
    @(negedge clk);
    chk("wr_bvalid_clr", 32'(s_bvalid), 32'd0);
    s_bready = 1'b0;

    // Zero-wait read, response held under rready backpressure.
    @(negedge clk);
    s_araddr = 32'h0000_0024; s_arvalid = 1'b1; readdata = 32'h1234_5678;
    #1;
    chk("rd_arready", 32'(s_arready), 32'd1);
    chk("rd_awready", 32'(s_awready), 32'd0);
    @(negedge clk);
    s_arvalid = 1'b0;
    chk("rd_read_hi", 32'(amm.read), 32'd1);
    chk("rd_write_lo", 32'(amm.write), 32'd0);
    chk("rd_address", amm.address, 32'h0000_0024);
    chk("rd_be", 32'(amm.byteenable), 32'hF);
    @(negedge clk);
    chk("rd_read_lo", 32'(amm.read), 32'd0);
    chk("rd_rvalid", 32'(s_rvalid), 32'd1);
    chk("rd_rdata", s_rdata, 32'h1234_5678);
    readdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rd_hold_rvalid", 32'(s_rvalid), 32'd1);
      chk("rd_hold_rdata", s_rdata, 32'h1234_5678);
    end
    s_rready = 1'b1;
    @(negedge clk);
    chk("rd_rvalid_clr", 32'(s_rvalid), 32'd0);
    s_rready = 1'b0;

    // AW without W waits; both halves accepted together. Also address mask.
    @(negedge clk);
    s_awaddr = 32'hFFFF_1237; s_wdata = 32'hA5A5_A5A5; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk("aw_only_awready", 32'(s_awready), 32'd0);
      chk("aw_only_wready", 32'(s_wready), 32'd0);
    end
    @(negedge clk);
    s_wvalid = 1'b1;
    #1;
    chk("aw_w_awready", 32'(s_awready), 32'd1);
    chk("aw_w_wready", 32'(s_wready), 32'd1);
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    chk("mask_write", 32'(amm.write), 32'd1);
    chk("nomask_address", amm.address, 32'hFFFF_1237);
    chk("mask_address", amm_m.address, 32'h0000_0234);
    @(negedge clk);
    chk("aw_w_bvalid", 32'(s_bvalid), 32'd1);
    s_bready = 1'b1;
    @(negedge clk);
    s_bready = 1'b0;

    // Reset asserted mid-write while waitrequest stalls the command.
    @(negedge clk);
    s_awaddr = 32'h0000_0040; s_wdata = 32'h1111_2222; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1; waitrequest = 1'b1;
    @(negedge clk);
    chk("arst_pre_write", 32'(amm.write), 32'd1);
    s_araddr = 32'h0000_0080; s_arvalid = 1'b1; readdata = 32'hCAFE_F00D;
    #2 reset = 1'b1;
    #1;
    chk("arst_write", 32'(amm.write), 32'd0);
    chk("arst_bvalid", 32'(s_bvalid), 32'd0);
    chk("arst_awready", 32'(s_awready), 32'd0);
    chk("arst_wready", 32'(s_wready), 32'd0);
    chk("arst_arready", 32'(s_arready), 32'd0);
    s_bready = 1'b1; s_rready = 1'b1; waitrequest = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("contend_awready", 32'(s_awready), 32'd1);
    chk("contend_arready", 32'(s_arready), 32'd0);

    // Continuous contention from reset: grants must alternate W,R,W,R.
    grants  = 4'b0000;
    ng      = 0;
    both_hi = 1'b0;
    for (int cyc = 0; cyc < 40 && ng < 4; cyc++) begin
      @(negedge clk);
      if (amm.read && amm.write) both_hi = 1'b1;
      if (amm.write) begin
        grants[ng] = 1'b1;
        if (ng == 0) begin
          chk("post_rst_address", amm.address, 32'h0000_0040);
          chk("post_rst_wdata", amm.writedata, 32'h1111_2222);
        end
        ng++;
      end else if (amm.read) begin
        grants[ng] = 1'b0;
        if (ng == 1) chk("contend_rd_address", amm.address, 32'h0000_0080);
        ng++;
      end
    end
    chk("grant_count", 32'(ng), 32'd4);
    chk("grant_order", 32'(grants), 32'h5);
    chk("never_both", 32'(both_hi), 32'd0);
    chk("contend_rdata", s_rdata, 32'hCAFE_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axi4lite_amm_bridge.md
Name: axi4lite_amm_bridge

Overview:
Single-clock AXI4-Lite slave to Avalon-MM master converter. It sits directly upstream of the clock-domain Avalon-MM synchronizer: a CPU-side AXI4-Lite port drives this block, and its amm_if master port feeds the synchronizer's slave port. It handles one transaction at a time and has no outstanding-transaction pipelining, so it is always correct behind a slow, variable-latency crossing.

Parameters:
P_ADDR_MASK, 32'hFFFF_FFFF, ANDed with the AXI address before it is driven on o.address.
P_RD_FIRST, 0, 1 = read wins the first simultaneous read/write contention after reset; 0 = write wins.

Ports:
clk  in  1  single clock; all logic posedge.
reset  in  1  asynchronous, active-high reset.
s_awaddr  in  32  write address.
s_awvalid  in  1  write address valid.
s_awready  out  1  write address accepted.
s_wdata  in  32  write data.
s_wstrb  in  4  write byte strobes.
s_wvalid  in  1  write data valid.
s_wready  out  1  write data accepted.
s_bresp  out  2  write response, always 2'b00 (OKAY).
s_bvalid  out  1  write response valid.
s_bready  in  1  write response accepted.
s_araddr  in  32  read address.
s_arvalid  in  1  read address valid.
s_arready  out  1  read address accepted.
s_rdata  out  32  read data.
s_rresp  out  2  read response, always 2'b00.
s_rvalid  out  1  read data valid.
s_rready  in  1  read data accepted.
o  amm_if.master  -  Avalon-MM master: address/writedata/byteenable/read/write out; readdata/waitrequest in.

Behaviour:
- FSM states: IDLE, AMM_WR, AMM_RD, B_RESP, R_RESP; held in registers.
- Reset (async) values:
  - state=IDLE; o.read=o.write=0; s_bvalid=s_rvalid=0.
  - o.address/o.writedata/o.byteenable=0; s_rdata=0.
  - Priority flag = P_RD_FIRST.
  - s_awready/s_wready/s_arready are combinational and forced to 0 while reset is high.
- Write request in IDLE: s_awvalid & s_wvalid both high.
- Read request in IDLE: s_arvalid high.
- In IDLE the readies are combinational:
  - s_awready = s_wready = wr_req & grant_wr.
  - s_arready = rd_req & ~grant_wr.
  - grant_wr = wr_req & (~rd_req | ~prio_rd).
  - AW and W are always accepted in the same cycle. AW without W (or W without AW) is never accepted and waits.
- Priority: after each granted transaction, prio_rd <= (the granted one was a write). Simultaneous contention therefore alternates strictly.
- Accept write (cycle 0): register o.address = s_awaddr & P_ADDR_MASK, o.writedata, o.byteenable = s_wstrb; o.write<=1; state->AMM_WR.
- AMM_WR: hold o.write and all o.* stable while o.waitrequest=1. In the cycle o.waitrequest=0: o.write<=0, s_bvalid<=1, state->B_RESP.
- B_RESP: hold s_bvalid until s_bready; then s_bvalid<=0, state->IDLE. New requests are accepted no earlier than the cycle after.
- Accept read: register o.address, o.byteenable=4'hF; o.read<=1; state->AMM_RD.
- AMM_RD: in the cycle o.waitrequest=0: capture s_rdata<=o.readdata, o.read<=0, s_rvalid<=1, state->R_RESP.
- R_RESP: hold s_rvalid/s_rdata stable until s_rready; then -> IDLE.
- Latency with zero-wait Avalon and ready master:
  - o.write/o.read assert 1 cycle after the AXI handshake.
  - bvalid/rvalid assert 1 cycle after the waitrequest=0 cycle.
  - Minimum 3 cycles per transaction, plus one idle cycle before the next accept.
- o.read and o.write are never both high. At most one transaction is outstanding.
- Reset mid-transaction: all state clears immediately, and any in-flight Avalon command is dropped (o.read/o.write go low asynchronously).

Decomposition:
- Shared package axi4lite_pkg: the FSM state enum typedef, and the localparams RESP_OKAY=2'b00, AMM_DW=32, AMM_AW=32.
- No sub-module; the FSM plus datapath registers stay in one module.

Test Plan:
- Write 0x0000_0010 / 0xDEADBEEF / strb 4'b0011 with waitrequest held 3 cycles -> o.write high exactly 4 cycles with stable address/data/byteenable 0x3; bvalid=1, bresp=0 the next cycle.
- Read 0x24 with waitrequest=0 and readdata=0x12345678 -> o.read pulses 1 cycle; rvalid=1, rdata=0x12345678; rdata held while rready=0 for 5 cycles.
- awvalid high with wvalid low for 4 cycles, then wvalid high -> awready/wready stay 0 until both are valid, then both go 1 in the same cycle.
- Read and write continuously pending from reset (P_RD_FIRST=0) -> grants go W,R,W,R; o.read and o.write are never both high.
- P_ADDR_MASK=32'h0000_0FFC with awaddr 0xFFFF_1237 -> o.address=0x0000_0234.
- Assert reset while in AMM_WR with waitrequest=1 -> o.write, bvalid and readies drop to 0 without waiting for a clock edge; after release the next write completes normally.
